// File: rtl/unet_host_sequencer.sv
// unet_host_sequencer
//   Host-side driver for the unet accelerator handshake. It loads the weight set
//   (optional), streams one input frame, waits for the result and then collects
//   the output frame into output memory. It repeats this for a batch of frames,
//   optionally compares each output word against expected memory, and has a
//   watchdog that aborts a run whose accelerator stops making progress.
//
// Ports
//   clk, rst_n                   clock, async active-low reset
//   start_i                      one-cycle run request, ignored unless idle
//   load_weights_i               sampled at start: send weights before frame 0
//   num_frames_i[7:0]            sampled at start: frames in batch (0 means 1)
//   cmp_en_i                     sampled at start: compare outputs to expected
//   busy_o, done_o               run in progress / one-cycle end-of-run pulse
//   timeout_err_o                watchdog abort, held until the next start
//   err_count_o[15:0]            saturating mismatch count for the run
//   acc_enpulse_o                handshake pulse to the accelerator
//   acc_ctrl_i[2:0]              accelerator status code
//   acc_data_in_o, acc_data_out_i  data to / from accelerator
//   src_rd_addr_o, src_sel_o, src_rd_data_i   weight(0)/input(1) memory read
//   exp_rd_addr_o, exp_rd_data_i              expected-output memory read
//   out_wr_en_o, out_wr_addr_o, out_wr_data_o output memory write
//
// state    | meaning
// IDLE     | waiting for start
// REQ_W    | accelerator idle expected, pulse to begin weight load
// SEND_W   | weight words consumed while status is SEND_WEIGHTS
// REQ_D    | accelerator idle expected, pulse to begin input frame
// SEND_D   | input words consumed while status is SEND_DATA
// WAIT_RDY | accelerator computing, pulse once DATA_READY
// RECV     | output words written while status is SENDING
// DONE     | one-cycle end of run, back to IDLE
module unet_host_sequencer #(
    parameter int DW        = 32,
    parameter int AW        = 24,
    parameter int N_WEIGHTS = 1680,
    parameter int N_INPUT   = 49218,
    parameter int N_OUTPUT  = 65536,
    parameter int TMO_W     = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          load_weights_i,
    input  logic [7:0]    num_frames_i,
    input  logic          cmp_en_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          timeout_err_o,
    output logic [15:0]   err_count_o,
    output logic          acc_enpulse_o,
    input  logic [2:0]    acc_ctrl_i,
    output logic [DW-1:0] acc_data_in_o,
    input  logic [DW-1:0] acc_data_out_i,
    output logic [AW-1:0] src_rd_addr_o,
    output logic          src_sel_o,
    input  logic [DW-1:0] src_rd_data_i,
    output logic [AW-1:0] exp_rd_addr_o,
    input  logic [DW-1:0] exp_rd_data_i,
    output logic          out_wr_en_o,
    output logic [AW-1:0] out_wr_addr_o,
    output logic [DW-1:0] out_wr_data_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ_W, S_SEND_W, S_REQ_D, S_SEND_D, S_WAIT_RDY, S_RECV, S_DONE
    } state_t;

    localparam logic [2:0] CTRL_SEND_W  = 3'd1;
    localparam logic [2:0] CTRL_SEND_D  = 3'd2;
    localparam logic [2:0] CTRL_RDY     = 3'd3;
    localparam logic [2:0] CTRL_SENDING = 3'd4;
    localparam logic [2:0] CTRL_IDLE    = 3'd5;

    localparam logic [AW-1:0]    LAST_W    = AW'(N_WEIGHTS - 1);
    localparam logic [AW-1:0]    LAST_I    = AW'(N_INPUT - 1);
    localparam logic [AW-1:0]    LAST_O    = AW'(N_OUTPUT - 1);
    localparam logic [AW-1:0]    STEP_IN   = AW'(N_INPUT);
    localparam logic [AW-1:0]    STEP_OUT  = AW'(N_OUTPUT);
    localparam logic [TMO_W-1:0] WD_RELOAD = '1;
    localparam logic [TMO_W-1:0] WD_TC     = TMO_W'(1);

    state_t           state_q;
    logic [AW-1:0]    cnt_q;
    logic [AW-1:0]    in_base_q;
    logic [AW-1:0]    out_base_q;
    logic [7:0]       frames_q;
    logic [7:0]       frame_idx_q;
    logic             cmp_en_q;
    logic             busy_q;
    logic             done_q;
    logic             timeout_err_q;
    logic             enpulse_q;
    logic [15:0]      err_count_q;
    logic [TMO_W-1:0] wd_q;

    logic take_w, take_d, hs_req, hs_rdy, take_out, progress, mismatch;

    assign take_w   = (state_q == S_SEND_W) && (acc_ctrl_i == CTRL_SEND_W);
    assign take_d   = (state_q == S_SEND_D) && (acc_ctrl_i == CTRL_SEND_D);
    assign hs_req   = ((state_q == S_REQ_W) || (state_q == S_REQ_D)) && (acc_ctrl_i == CTRL_IDLE);
    assign hs_rdy   = (state_q == S_WAIT_RDY) && (acc_ctrl_i == CTRL_RDY);
    assign take_out = (state_q == S_RECV) && (acc_ctrl_i == CTRL_SENDING);
    assign progress = take_w | take_d | hs_req | hs_rdy | take_out;
    assign mismatch = cmp_en_q && (acc_data_out_i != exp_rd_data_i);

    // Frame bases are running sums of the per-frame word count, which equals
    // frame_idx * N modulo 2**AW without needing a multiplier.
    assign src_rd_addr_o = (state_q == S_SEND_D) ? in_base_q + cnt_q :
                           (state_q == S_SEND_W) ? cnt_q : '0;
    assign src_sel_o     = (state_q == S_SEND_D);
    assign out_wr_addr_o = out_base_q + cnt_q;
    assign exp_rd_addr_o = out_wr_addr_o;
    assign out_wr_en_o   = take_out;
    assign out_wr_data_o = acc_data_out_i;
    assign acc_data_in_o = src_rd_data_i;

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign timeout_err_o = timeout_err_q;
    assign err_count_o   = err_count_q;
    assign acc_enpulse_o = enpulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            in_base_q     <= '0;
            out_base_q    <= '0;
            frames_q      <= '0;
            frame_idx_q   <= '0;
            cmp_en_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            enpulse_q     <= 1'b0;
            err_count_q   <= '0;
            wd_q          <= '0;
        end else begin
            enpulse_q <= 1'b0;
            done_q    <= 1'b0;

            // Watchdog counts down stalled busy cycles; every state change in a
            // busy run comes from a progress event, so that reload covers it.
            if (progress) begin
                wd_q <= WD_RELOAD;
            end else if (busy_q) begin
                wd_q <= wd_q - TMO_W'(1);
            end

            if (busy_q && !progress && (wd_q == WD_TC)) begin
                timeout_err_q <= 1'b1;
                busy_q        <= 1'b0;
                done_q        <= 1'b1;
                state_q       <= S_DONE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            cmp_en_q      <= cmp_en_i;
                            frames_q      <= (num_frames_i == 8'd0) ? 8'd1 : num_frames_i;
                            frame_idx_q   <= '0;
                            cnt_q         <= '0;
                            in_base_q     <= '0;
                            out_base_q    <= '0;
                            err_count_q   <= '0;
                            timeout_err_q <= 1'b0;
                            busy_q        <= 1'b1;
                            wd_q          <= WD_RELOAD;
                            state_q       <= load_weights_i ? S_REQ_W : S_REQ_D;
                        end
                    end
                    S_REQ_W: begin
                        if (hs_req) begin
                            enpulse_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= S_SEND_W;
                        end
                    end
                    S_SEND_W: begin
                        if (take_w) begin
                            if (cnt_q == LAST_W) begin
                                cnt_q   <= '0;
                                state_q <= S_REQ_D;
                            end else begin
                                cnt_q <= cnt_q + AW'(1);
                            end
                        end
                    end
                    S_REQ_D: begin
                        if (hs_req) begin
                            enpulse_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= S_SEND_D;
                        end
                    end
                    S_SEND_D: begin
                        if (take_d) begin
                            if (cnt_q == LAST_I) begin
                                cnt_q   <= '0;
                                state_q <= S_WAIT_RDY;
                            end else begin
                                cnt_q <= cnt_q + AW'(1);
                            end
                        end
                    end
                    S_WAIT_RDY: begin
                        if (hs_rdy) begin
                            enpulse_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= S_RECV;
                        end
                    end
                    S_RECV: begin
                        if (take_out) begin
                            if (mismatch && (err_count_q != 16'hFFFF)) begin
                                err_count_q <= err_count_q + 16'd1;
                            end
                            if (cnt_q == LAST_O) begin
                                cnt_q       <= '0;
                                frame_idx_q <= frame_idx_q + 8'd1;
                                in_base_q   <= in_base_q + STEP_IN;
                                out_base_q  <= out_base_q + STEP_OUT;
                                if (frame_idx_q == frames_q - 8'd1) begin
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    state_q <= S_DONE;
                                end else begin
                                    state_q <= S_REQ_D;
                                end
                            end else begin
                                cnt_q <= cnt_q + AW'(1);
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
